// File: rtl/param_ram_ctrl_pkg.sv
// Shared types, limits and the byte-lane merge helper for the parametrised RAM controller.
package ram_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Widest word the merge helper handles; callers zero-extend narrower words into it.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] wdata,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/param_ram_ctrl_rd_pipe.sv
// Fixed-depth valid/data shift register for read responses; data stages only load
// behind a valid bit, so the last stage holds the most recent response.
module rd_pipe #(
    parameter int DATA_W = 8,
    parameter int STAGES = 1
) (
    input  logic              i_clk,
    input  logic              i_flush_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [STAGES-1:0] r_valid;
    logic [DATA_W-1:0] r_data [STAGES];

    // NOTE: sequential state is updated with <= only, so every stage sees the
    // pre-edge value of its neighbour regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_flush_n) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_valid = r_valid[STAGES-1];
    assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/param_ram_ctrl.sv
// Single-port RAM controller: valid/ready requests, byte-enabled writes,
// fixed-latency reads and a sequential clear engine over an inferred array.
module param_ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int RD_LAT       = 1,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic                clr_start,
    output logic                busy,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_chk_rd_lat
        $fatal(1, "param_ram_ctrl: RD_LAT must lie within 1..3");
    end
    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_chk_data_w
        $fatal(1, "param_ram_ctrl: DATA_W must be a non-zero multiple of 8");
    end

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic              r_rst_hold;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_busy;
    logic w_ready;
    logic w_accept;
    logic w_wr_en;
    logic w_rd_en;

    // r_rst_hold keeps ready/busy low for the cycle following a reset edge
    // while still decoding them from registers only.
    assign w_busy   = (r_state == CLEAR) && !r_rst_hold;
    assign w_ready  = (r_state == IDLE) && !r_rst_hold;
    assign w_accept = req_valid && w_ready && !clr_start;
    assign w_wr_en  = w_accept && req_we;
    assign w_rd_en  = w_accept && !req_we;

    assign busy      = w_busy;
    assign req_ready = w_ready;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            if (CLEAR_ON_RST) begin
                r_state <= CLEAR;
            end else begin
                r_state <= IDLE;
            end
            r_clr_cnt  <= '0;
            r_rst_hold <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_rst_hold <= 1'b0;
        end
    end

    // NOTE: both next-state outputs get a default before the case, so no path
    // through this block leaves them unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            IDLE: begin
                if (w_ready && clr_start) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                if (w_busy) begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                    if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: the array has no reset branch; clearing it is the clear engine's job,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            if (w_busy) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_en) begin
                r_mem[req_addr] <= DATA_W'(be_merge(MAX_DATA_W'(r_mem[req_addr]),
                                                    MAX_DATA_W'(req_wdata),
                                                    MAX_BE_W'(req_be)));
            end
        end
    end

    rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT)
    ) u_rd_pipe (
        .i_clk     (sys_clk),
        .i_flush_n (sys_rst),
        .i_valid   (w_rd_en),
        .i_data    (r_mem[req_addr]),
        .o_valid   (rsp_valid),
        .o_data    (rsp_data)
    );

endmodule

// File: tb/tb_param_ram_ctrl.sv
// Directed bench for param_ram_ctrl using three configurations: 8-bit/RD_LAT=1 with
// clear-on-reset, 32-bit/RD_LAT=2 without it, and 8-bit/RD_LAT=3 with it.
module tb_param_ram_ctrl;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Configuration A: DATA_W=8, RD_LAT=1, CLEAR_ON_RST=1
    logic       a_rst, a_valid, a_ready, a_we, a_clr, a_busy, a_rsp_valid;
    logic [3:0] a_addr;
    logic [7:0] a_wdata, a_rsp_data;
    logic [0:0] a_be;

    // Configuration B: DATA_W=32, RD_LAT=2, CLEAR_ON_RST=0
    logic        b_rst, b_valid, b_ready, b_we, b_clr, b_busy, b_rsp_valid;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata, b_rsp_data;
    logic [3:0]  b_be;

    // Configuration C: DATA_W=8, RD_LAT=3, CLEAR_ON_RST=1
    logic       c_rst, c_valid, c_ready, c_we, c_clr, c_busy, c_rsp_valid;
    logic [3:0] c_addr;
    logic [7:0] c_wdata, c_rsp_data;
    logic [0:0] c_be;

    param_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RST(1'b1)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .clr_start(a_clr), .busy(a_busy), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data)
    );

    param_ram_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .CLEAR_ON_RST(1'b0)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst(b_rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .clr_start(b_clr), .busy(b_busy), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data)
    );

    param_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LAT(3), .CLEAR_ON_RST(1'b1)) u_dut_c (
        .sys_clk(sys_clk), .sys_rst(c_rst), .req_valid(c_valid), .req_ready(c_ready),
        .req_we(c_we), .req_addr(c_addr), .req_wdata(c_wdata), .req_be(c_be),
        .clr_start(c_clr), .busy(c_busy), .rsp_valid(c_rsp_valid), .rsp_data(c_rsp_data)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        int cyc;
        bit bad_ready;
        tick();
        tick();
        n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else n_pass++;
        n_checks++; if (a_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", a_ready); else n_pass++;
        n_checks++; if (a_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", a_rsp_valid); else n_pass++;
        n_checks++; if (a_rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %h want 00", a_rsp_data); else n_pass++;
        a_rst = 1'b1;
        cyc = 0;
        bad_ready = 1'b0;
        tick();
        while (a_busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (a_ready !== 1'b0) bad_ready = 1'b1;
            tick();
        end
        n_checks++; if (cyc != 16) $display("FAIL reset_clear_len: got %0d cycles want 16", cyc); else n_pass++;
        n_checks++; if (bad_ready) $display("FAIL reset_clear_ready: got ready=1 during clear want 0"); else n_pass++;
        n_checks++; if (a_ready !== 1'b1) $display("FAIL reset_clear_done_ready: got %b want 1", a_ready); else n_pass++;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 4'hF;
        tick();
        a_valid = 1'b0;
        n_checks++; if (a_rsp_valid !== 1'b1) $display("FAIL read_F_valid: got %b want 1", a_rsp_valid); else n_pass++;
        n_checks++; if (a_rsp_data !== 8'h00) $display("FAIL read_F_data: got %h want 00", a_rsp_data); else n_pass++;
        tick();
        n_checks++; if (a_rsp_valid !== 1'b0) $display("FAIL read_F_pulse: got %b want 0", a_rsp_valid); else n_pass++;
    endtask

    task automatic test_write_then_read();
        a_valid = 1'b1; a_we = 1'b1; a_addr = 4'h9; a_wdata = 8'h3C; a_be = 1'b1;
        tick();
        n_checks++; if (a_rsp_valid !== 1'b0) $display("FAIL write_no_rsp: got %b want 0", a_rsp_valid); else n_pass++;
        a_we = 1'b0;
        tick();
        a_valid = 1'b0;
        n_checks++; if (a_rsp_valid !== 1'b1) $display("FAIL wr_rd_valid: got %b want 1", a_rsp_valid); else n_pass++;
        n_checks++; if (a_rsp_data !== 8'h3C) $display("FAIL wr_rd_data: got %h want 3c", a_rsp_data); else n_pass++;
        tick();
        n_checks++; if (a_rsp_valid !== 1'b0) $display("FAIL wr_rd_pulse: got %b want 0", a_rsp_valid); else n_pass++;
        n_checks++; if (a_rsp_data !== 8'h3C) $display("FAIL rsp_data_hold: got %h want 3c", a_rsp_data); else n_pass++;
    endtask

    task automatic test_clr_start();
        int cyc;
        // clr_start wins over a simultaneous read; a second pulse mid-clear is ignored
        a_valid = 1'b1; a_we = 1'b0; a_addr = 4'h9; a_clr = 1'b1;
        tick();
        a_valid = 1'b0; a_clr = 1'b0;
        n_checks++; if (a_rsp_valid !== 1'b0) $display("FAIL clr_blocks_req: got rsp_valid %b want 0", a_rsp_valid); else n_pass++;
        n_checks++; if (a_busy !== 1'b1) $display("FAIL clr_start_busy: got %b want 1", a_busy); else n_pass++;
        cyc = 1;
        while (a_busy === 1'b1 && cyc < 40) begin
            a_clr = (cyc == 5);
            tick();
            a_clr = 1'b0;
            if (a_busy === 1'b1) cyc++;
        end
        n_checks++; if (cyc != 16) $display("FAIL clr_len_repulse: got %0d cycles want 16", cyc); else n_pass++;
        n_checks++; if (a_ready !== 1'b1) $display("FAIL clr_done_ready: got %b want 1", a_ready); else n_pass++;
        a_valid = 1'b1; a_addr = 4'h9;
        tick();
        a_valid = 1'b0;
        n_checks++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h00)
            $display("FAIL clr_zeroed_9: got valid %b data %h want 1/00", a_rsp_valid, a_rsp_data); else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        a_valid = 1'b1; a_we = 1'b1; a_addr = 4'hE; a_wdata = 8'hEE; a_be = 1'b1;
        tick();
        a_valid = 1'b0; a_we = 1'b0; a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        for (int i = 1; i < 7; i++) tick();
        n_checks++; if (a_busy !== 1'b1) $display("FAIL mid_clear_busy: got %b want 1", a_busy); else n_pass++;
        a_rst = 1'b0;
        tick();
        n_checks++; if (a_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", a_busy); else n_pass++;
        n_checks++; if (a_rsp_valid !== 1'b0) $display("FAIL mid_rst_rsp_valid: got %b want 0", a_rsp_valid); else n_pass++;
        n_checks++; if (a_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", a_ready); else n_pass++;
        a_rst = 1'b1;
        cyc = 0;
        tick();
        while (a_busy === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
        n_checks++; if (cyc != 16) $display("FAIL mid_rst_clear_len: got %0d cycles want 16", cyc); else n_pass++;
        a_valid = 1'b1; a_addr = 4'hE;
        tick();
        a_valid = 1'b0;
        n_checks++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 8'h00)
            $display("FAIL mid_rst_zeroed_E: got valid %b data %h want 1/00", a_rsp_valid, a_rsp_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [7:0] pre [3];
        pre[0] = 8'hA1; pre[1] = 8'hA2; pre[2] = 8'hA3;
        c_rst = 1'b1;
        cyc = 0;
        tick();
        while (c_busy === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
        n_checks++; if (c_ready !== 1'b1) $display("FAIL c_init_ready: got %b want 1", c_ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            c_valid = 1'b1; c_we = 1'b1; c_be = 1'b1; c_addr = 4'(i + 1); c_wdata = pre[i];
            tick();
        end
        c_we = 1'b0; c_addr = 4'h1;
        tick();
        n_checks++; if (c_rsp_valid !== 1'b0) $display("FAIL b2b_lat_1: got %b want 0", c_rsp_valid); else n_pass++;
        c_addr = 4'h2;
        tick();
        n_checks++; if (c_rsp_valid !== 1'b0) $display("FAIL b2b_lat_2: got %b want 0", c_rsp_valid); else n_pass++;
        c_addr = 4'h3;
        tick();
        c_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_checks++; if (c_rsp_valid !== 1'b1 || c_rsp_data !== pre[i])
                $display("FAIL b2b_rsp_%0d: got valid %b data %h want 1/%h", i, c_rsp_valid, c_rsp_data, pre[i]); else n_pass++;
        end
        tick();
        n_checks++; if (c_rsp_valid !== 1'b0 || c_rsp_data !== 8'hA3)
            $display("FAIL b2b_end: got valid %b data %h want 0/a3", c_rsp_valid, c_rsp_data); else n_pass++;
    endtask

    task automatic test_clear_inflight();
        int cyc;
        bit got;
        c_valid = 1'b1; c_we = 1'b1; c_be = 1'b1; c_addr = 4'h5; c_wdata = 8'h5A;
        tick();
        c_we = 1'b0;
        tick();
        c_valid = 1'b0; c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        n_checks++; if (c_busy !== 1'b1 || c_rsp_valid !== 1'b0)
            $display("FAIL inflight_start: got busy %b valid %b want 1/0", c_busy, c_rsp_valid); else n_pass++;
        tick();
        n_checks++; if (c_rsp_valid !== 1'b1 || c_rsp_data !== 8'h5A)
            $display("FAIL inflight_rsp: got valid %b data %h want 1/5a", c_rsp_valid, c_rsp_data); else n_pass++;
        cyc = (c_busy === 1'b1) ? 2 : 0;
        while (c_busy === 1'b1 && cyc < 40) begin
            tick();
            if (c_busy === 1'b1) cyc++;
        end
        n_checks++; if (cyc != 16) $display("FAIL inflight_clear_len: got %0d cycles want 16", cyc); else n_pass++;
        c_valid = 1'b1; c_addr = 4'h5;
        tick();
        c_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (c_rsp_valid === 1'b1) got = 1'b1;
            else tick();
        end
        n_checks++; if (!got || c_rsp_data !== 8'h00)
            $display("FAIL inflight_zeroed_5: got seen %b data %h want 1/00", got, c_rsp_data); else n_pass++;
    endtask

    task automatic test_byte_merge();
        tick();
        n_checks++; if (b_ready !== 1'b0 || b_busy !== 1'b0)
            $display("FAIL b_reset: got ready %b busy %b want 0/0", b_ready, b_busy); else n_pass++;
        b_rst = 1'b1;
        tick();
        n_checks++; if (b_ready !== 1'b1 || b_busy !== 1'b0)
            $display("FAIL b_no_clear: got ready %b busy %b want 1/0", b_ready, b_busy); else n_pass++;
        b_valid = 1'b1; b_we = 1'b1; b_addr = 4'h3; b_wdata = 32'hDEADBEEF; b_be = 4'hF;
        tick();
        b_wdata = 32'h11223344; b_be = 4'b0101;
        tick();
        b_wdata = 32'hFFFFFFFF; b_be = 4'b0000;
        tick();
        b_we = 1'b0;
        tick();
        b_valid = 1'b0;
        n_checks++; if (b_rsp_valid !== 1'b0) $display("FAIL merge_lat: got %b want 0", b_rsp_valid); else n_pass++;
        tick();
        n_checks++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'hDE22BE44)
            $display("FAIL merge_data: got valid %b data %h want 1/de22be44", b_rsp_valid, b_rsp_data); else n_pass++;
        tick();
        n_checks++; if (b_rsp_valid !== 1'b0) $display("FAIL merge_pulse: got %b want 0", b_rsp_valid); else n_pass++;
    endtask

    initial begin
        a_rst = 1'b0; a_valid = 1'b0; a_we = 1'b0; a_clr = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_rst = 1'b0; b_valid = 1'b0; b_we = 1'b0; b_clr = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        c_rst = 1'b0; c_valid = 1'b0; c_we = 1'b0; c_clr = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
        test_reset();
        test_write_then_read();
        test_clr_start();
        test_reset_mid_clear();
        test_back_to_back();
        test_clear_inflight();
        test_byte_merge();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
